// File: rtl/taxi_fare_counter_pkg.sv
// Shared definitions for the taxi meter: FSM states, BCD limits and default tariff.
package meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned BCD_W   = 4;
  localparam logic [11:0] BCD_MAX = 12'h999;

  localparam logic [11:0] DEF_BASE_FARE  = 12'h010;
  localparam logic [9:0]  DEF_BASE_DIST  = 10'd30;
  localparam logic [3:0]  DEF_PER_STEP   = 4'd5;
  localparam logic [3:0]  DEF_PER_PRICE  = 4'd1;
  localparam logic [31:0] DEF_WAIT_CYC   = 32'd50_000_000;
  localparam logic [3:0]  DEF_WAIT_PRICE = 4'd1;

endpackage

// File: rtl/taxi_fare_counter_bcd3_inc_sat.sv
// Combinational 3-digit BCD plus one BCD digit, saturating at 999.
module bcd3_inc_sat
  import meter_pkg::*;
(
  input  logic [3*BCD_W-1:0] i_val,
  input  logic [BCD_W-1:0]   i_add,
  output logic [3*BCD_W-1:0] o_sum
);

  logic [BCD_W:0]     w_dig;
  logic               w_cy;
  logic [3*BCD_W-1:0] w_res;

  always_comb begin
    w_dig = '0;
    w_cy  = 1'b0;
    w_res = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_dig = {1'b0, i_val[k*BCD_W +: BCD_W]} + {4'd0, w_cy};
      if (k == 0) w_dig = w_dig + {1'b0, i_add};
      if (w_dig > 5'd9) begin
        w_dig = w_dig - 5'd10;
        w_cy  = 1'b1;
      end else begin
        w_cy  = 1'b0;
      end
      w_res[k*BCD_W +: BCD_W] = w_dig[BCD_W-1:0];
    end
    o_sum = w_cy ? BCD_MAX : w_res;
  end

endmodule

// File: rtl/taxi_fare_counter.sv
// Taxi trip meter: BCD distance from wheel pulses and BCD fare with base,
// per-distance-step and waiting charges.
module taxi_fare_counter
  import meter_pkg::*;
#(
  parameter logic [11:0] BASE_FARE  = DEF_BASE_FARE,
  parameter logic [9:0]  BASE_DIST  = DEF_BASE_DIST,
  parameter logic [3:0]  PER_STEP   = DEF_PER_STEP,
  parameter logic [3:0]  PER_PRICE  = DEF_PER_PRICE,
  parameter logic [31:0] WAIT_CYC   = DEF_WAIT_CYC,
  parameter logic [3:0]  WAIT_PRICE = DEF_WAIT_PRICE
) (
  input  logic        clkc,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pulse_100m,
  output logic [11:0] dis_bcd,
  output logic [11:0] price_bcd,
  output logic        running
);

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_dbin;
  logic [3:0]  r_seg;
  logic [31:0] r_wait;

  logic        w_enter, w_meter, w_pulse_ok, w_past_base;
  logic        w_dist_chg, w_wait_chg;
  logic [4:0]  w_seg_inc;
  logic [3:0]  w_add_dig;
  logic [11:0] w_dis_inc, w_price_add;

  always_ff @(posedge clkc) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // stop takes priority in RUN; start takes priority in IDLE/HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: if (start) w_state_nxt = ST_RUN;
      ST_RUN:           if (stop)  w_state_nxt = ST_HOLD;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_enter     = start && (r_state != ST_RUN);
    w_meter     = (r_state == ST_RUN) && !stop;
    w_pulse_ok  = pulse_100m && (dis_bcd != BCD_MAX);
    w_past_base = (r_dbin >= BASE_DIST);
    w_seg_inc   = {1'b0, r_seg} + 5'd1;
    w_dist_chg  = w_pulse_ok && w_past_base && (w_seg_inc == {1'b0, PER_STEP});
    // a wheel pulse always restarts the waiting interval, so it pre-empts expiry
    w_wait_chg  = !pulse_100m && (r_wait == WAIT_CYC - 32'd1);
    w_add_dig   = w_dist_chg ? PER_PRICE : WAIT_PRICE;
  end

  bcd3_inc_sat u_dis_inc (
    .i_val (dis_bcd),
    .i_add (4'd1),
    .o_sum (w_dis_inc)
  );

  bcd3_inc_sat u_price_add (
    .i_val (price_bcd),
    .i_add (w_add_dig),
    .o_sum (w_price_add)
  );

  always_ff @(posedge clkc) begin
    if (rst) begin
      dis_bcd   <= '0;
      price_bcd <= '0;
      running   <= 1'b0;
      r_dbin    <= '0;
      r_seg     <= '0;
      r_wait    <= '0;
    end else begin
      running <= (w_state_nxt == ST_RUN);
      if (w_enter) begin
        dis_bcd   <= '0;
        price_bcd <= BASE_FARE;
        r_dbin    <= '0;
        r_seg     <= '0;
        r_wait    <= '0;
      end else if (w_meter) begin
        if (pulse_100m || w_wait_chg) r_wait <= '0;
        else                          r_wait <= r_wait + 32'd1;
        if (w_pulse_ok) begin
          dis_bcd <= w_dis_inc;
          r_dbin  <= r_dbin + 10'd1;
          if (w_past_base) r_seg <= w_dist_chg ? 4'd0 : w_seg_inc[3:0];
        end
        if (w_dist_chg || w_wait_chg) price_bcd <= w_price_add;
      end
    end
  end

endmodule
